// File: rtl/vein_match_scorer_if.sv
// Signal bundle between the vein match scorer, its pixel source and the divider.
// The watchdog error flag exists only when MATCH_TIMEOUT_EN is defined.
interface vein_match_scorer_if;
  logic        frame_start;
  logic        pix_valid;
  logic        pix_ready;
  logic        tmpl_bit;
  logic        probe_bit;
  logic [15:0] threshold;
  logic        div_enable;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic [15:0] div_quotient;
  logic        div_done;
  logic [15:0] score;
  logic        match;
  logic        result_valid;
  logic        busy;
`ifdef MATCH_TIMEOUT_EN
  logic        div_err;
`endif

  modport slave (
`ifdef MATCH_TIMEOUT_EN
    output div_err,
`endif
    input  frame_start, pix_valid, tmpl_bit, probe_bit, threshold, div_quotient, div_done,
    output pix_ready, div_enable, div_dividend, div_divisor, score, match, result_valid, busy
  );

  modport master (
`ifdef MATCH_TIMEOUT_EN
    input  div_err,
`endif
    output frame_start, pix_valid, tmpl_bit, probe_bit, threshold, div_quotient, div_done,
    input  pix_ready, div_enable, div_dividend, div_divisor, score, match, result_valid, busy
  );
endinterface

// File: rtl/vein_match_scorer.sv
// Overlap/union scorer for finger-vein templates; drives an external divider for the ratio.
// Optional macro MATCH_TIMEOUT_EN adds a WAIT-state watchdog and the div_err flag.
module vein_match_scorer #(
  parameter int unsigned FRAME_PIX   = 1024,
  parameter int unsigned SCALE_SHIFT = 6,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               reset,
  vein_match_scorer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StAccum, StLaunch, StWait, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_pix_cnt, r_ovl_cnt, r_uni_cnt, r_score;
  logic        r_match, r_nomatch;
  logic        w_accept, w_last, w_clear, w_timeout, w_match_now;
  logic        w_ovl_bit, w_uni_bit;
  logic [15:0] w_uni_nxt;
  logic [31:0] w_scaled;

  // frame_start wins over a coincident beat, which is dropped
  assign w_clear   = bus.frame_start && (r_state == StIdle || r_state == StAccum);
  assign w_accept  = (r_state == StAccum) && bus.pix_valid && !bus.frame_start;
  assign w_ovl_bit = bus.tmpl_bit & bus.probe_bit;
  assign w_uni_bit = bus.tmpl_bit | bus.probe_bit;
  assign w_uni_nxt = r_uni_cnt + {15'd0, w_uni_bit};
  assign w_last    = w_accept && (r_pix_cnt + 16'd1 == 16'(FRAME_PIX));
  assign w_scaled  = 32'(r_ovl_cnt) << SCALE_SHIFT;

  assign w_match_now = !r_nomatch && (r_score >= bus.threshold);

`ifdef MATCH_TIMEOUT_EN
  logic [15:0] r_wd_cnt;
  logic        r_div_err;

  assign w_timeout   = (r_state == StWait) && !bus.div_done && (r_wd_cnt == 16'(TIMEOUT - 1));
  assign bus.div_err = r_div_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt  <= 16'd0;
      r_div_err <= 1'b0;
    end else begin
      r_wd_cnt <= (r_state == StWait) ? r_wd_cnt + 16'd1 : 16'd0;
      if (w_timeout) begin
        r_div_err <= 1'b1;
      end else if (r_state == StIdle && bus.frame_start) begin
        r_div_err <= 1'b0;
      end
    end
  end
`else
  logic [15:0] w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = 16'(TIMEOUT);
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (bus.frame_start) w_state_nxt = StAccum;
      StAccum:  if (w_last) w_state_nxt = (w_uni_nxt == 16'd0) ? StDone : StLaunch;
      StLaunch: w_state_nxt = StWait;
      StWait:   if (bus.div_done || w_timeout) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pix_cnt <= 16'd0;
      r_ovl_cnt <= 16'd0;
      r_uni_cnt <= 16'd0;
      r_score   <= 16'd0;
      r_match   <= 1'b0;
      r_nomatch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_pix_cnt <= 16'd0;
        r_ovl_cnt <= 16'd0;
        r_uni_cnt <= 16'd0;
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 16'd1;
        r_ovl_cnt <= r_ovl_cnt + {15'd0, w_ovl_bit};
        r_uni_cnt <= w_uni_nxt;
      end
      // Zero-union and watchdog exits force score 0 and suppress the match
      if (w_last && w_uni_nxt == 16'd0) begin
        r_score   <= 16'd0;
        r_nomatch <= 1'b1;
      end else if (r_state == StWait && bus.div_done) begin
        r_score   <= bus.div_quotient;
        r_nomatch <= 1'b0;
      end else if (w_timeout) begin
        r_score   <= 16'd0;
        r_nomatch <= 1'b1;
      end
      if (r_state == StDone) r_match <= w_match_now;
    end
  end

  // Counters are frozen in LAUNCH/WAIT, so the divider operands hold without extra registers
  assign bus.div_dividend = (|w_scaled[31:16]) ? 16'hFFFF : w_scaled[15:0];
  assign bus.div_divisor  = r_uni_cnt;
  assign bus.div_enable   = (r_state == StLaunch);
  assign bus.pix_ready    = (r_state == StAccum);
  assign bus.result_valid = (r_state == StDone);
  assign bus.busy         = (r_state != StIdle);
  assign bus.score        = r_score;
  assign bus.match        = (r_state == StDone) ? w_match_now : r_match;

endmodule

// File: tb/tb_vein_match_scorer.sv
// Directed bench for vein_match_scorer with a behavioural divider responder.
module tb_vein_match_scorer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vein_match_scorer_if bus();

  vein_match_scorer #(
    .FRAME_PIX  (1024),
    .SCALE_SHIFT(6),
    .TIMEOUT    (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int div_lat = 2;
  bit div_mute = 1'b0;
  int en_cnt = 0;
  int rv_cnt = 0;

  always @(negedge clk) begin
    if (bus.div_enable) en_cnt <= en_cnt + 1;
    if (bus.result_valid) rv_cnt <= rv_cnt + 1;
  end

  // Divider model: answers div_lat cycles after the start pulse, ignoring the scorer's state
  initial begin
    logic [15:0] dvd, dvs;
    bus.div_done     = 1'b0;
    bus.div_quotient = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (bus.div_enable && !div_mute) begin
        dvd = bus.div_dividend;
        dvs = bus.div_divisor;
        repeat (div_lat) begin @(posedge clk); #1; end
        bus.div_quotient = (dvs == 16'd0) ? 16'hFFFF : dvd / dvs;
        bus.div_done     = 1'b1;
        @(posedge clk); #1;
        bus.div_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, required completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic beat(input logic t, input logic p);
    bus.pix_valid = 1'b1;
    bus.tmpl_bit  = t;
    bus.probe_bit = p;
    step();
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int max);
    int k = 0;
    while (!bus.result_valid && k < max) begin
      step();
      k++;
    end
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd1);
  endtask

  // 256 (1,1), 256 (1,0), 512 (0,0)
  task automatic frame_mixed();
    start_frame();
    for (int i = 0; i < 1024; i++) begin
      if (i < 256) beat(1'b1, 1'b1);
      else if (i < 512) beat(1'b1, 1'b0);
      else beat(1'b0, 1'b0);
    end
  endtask

  initial begin
    int en_before, rv_before, k;
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.tmpl_bit    = 1'b0;
    bus.probe_bit   = 1'b0;
    bus.threshold   = 16'd0;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_enable", 32'(bus.div_enable), 32'd0);
    check("rst_dividend", 32'(bus.div_dividend), 32'd0);
    check("rst_divisor", 32'(bus.div_divisor), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_match", 32'(bus.match), 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    reset = 1'b0;
    step();

    // All-ones frame: saturated dividend
    bus.threshold = 16'd32;
    start_frame();
    check("f1_busy", 32'(bus.busy), 32'd1);
    check("f1_ready", 32'(bus.pix_ready), 32'd1);
    for (int i = 0; i < 1024; i++) beat(1'b1, 1'b1);
    check("f1_enable_t1", 32'(bus.div_enable), 32'd1);
    check("f1_dividend", 32'(bus.div_dividend), 32'd65535);
    check("f1_divisor", 32'(bus.div_divisor), 32'd1024);
    wait_result("f1", 20);
    check("f1_score", 32'(bus.score), 32'd63);
    check("f1_match", 32'(bus.match), 32'd1);
    step();
    check("f1_rv_one_cycle", 32'(bus.result_valid), 32'd0);
    check("f1_match_hold", 32'(bus.match), 32'd1);
    check("f1_idle", 32'(bus.busy), 32'd0);

    // Mixed frame below threshold
    bus.threshold = 16'd40;
    frame_mixed();
    check("f2_enable_t1", 32'(bus.div_enable), 32'd1);
    check("f2_dividend", 32'(bus.div_dividend), 32'd16384);
    check("f2_divisor", 32'(bus.div_divisor), 32'd512);
    wait_result("f2", 20);
    check("f2_score", 32'(bus.score), 32'd32);
    check("f2_match", 32'(bus.match), 32'd0);
    step();

    // Zero union: no divider launch, result at T+1, match forced low even at threshold 0
    bus.threshold = 16'd0;
    en_before = en_cnt;
    start_frame();
    for (int i = 0; i < 1024; i++) beat(1'b0, 1'b0);
    check("f3_rv_t1", 32'(bus.result_valid), 32'd1);
    check("f3_enable", 32'(bus.div_enable), 32'd0);
    check("f3_score", 32'(bus.score), 32'd0);
    check("f3_match", 32'(bus.match), 32'd0);
    step();
    check("f3_no_launch", 32'(en_cnt), 32'(en_before));
    check("f3_idle", 32'(bus.busy), 32'd0);

    // Restart mid-frame with gaps, dropped coincident beat, frame_start ignored in WAIT
    bus.threshold = 16'd64;
    div_lat = 6;
    start_frame();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      beat(1'b1, 1'b1);
    end
    bus.frame_start = 1'b1;
    bus.pix_valid   = 1'b1;
    bus.tmpl_bit    = 1'b1;
    bus.probe_bit   = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) beat(1'b1, 1'b1);
      else beat(1'b0, 1'b0);
    end
    check("f4_enable_t1", 32'(bus.div_enable), 32'd1);
    check("f4_dividend", 32'(bus.div_dividend), 32'd32768);
    check("f4_divisor", 32'(bus.div_divisor), 32'd512);
    step();
    start_frame();
    check("f4_wait_busy", 32'(bus.busy), 32'd1);
    check("f4_wait_ready", 32'(bus.pix_ready), 32'd0);
    wait_result("f4", 20);
    check("f4_score", 32'(bus.score), 32'd64);
    check("f4_match", 32'(bus.match), 32'd1);
    step();

    // Reset in WAIT with a late divider answer
    div_lat = 20;
    bus.threshold = 16'd40;
    frame_mixed();
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("f5_rst_busy", 32'(bus.busy), 32'd0);
    check("f5_rst_score", 32'(bus.score), 32'd0);
    check("f5_rst_match", 32'(bus.match), 32'd0);
    check("f5_rst_dividend", 32'(bus.div_dividend), 32'd0);
    check("f5_rst_divisor", 32'(bus.div_divisor), 32'd0);
    rv_before = rv_cnt;
    step();
    reset = 1'b0;
    repeat (25) step();
    check("f5_no_result", 32'(rv_cnt), 32'(rv_before));
    check("f5_idle", 32'(bus.busy), 32'd0);
    check("f5_score_kept0", 32'(bus.score), 32'd0);

    div_lat = 2;
    bus.threshold = 16'd30;
    frame_mixed();
    check("f6_dividend", 32'(bus.div_dividend), 32'd16384);
    check("f6_divisor", 32'(bus.div_divisor), 32'd512);
    wait_result("f6", 20);
    check("f6_score", 32'(bus.score), 32'd32);
    check("f6_match", 32'(bus.match), 32'd1);
    step();

`ifdef MATCH_TIMEOUT_EN
    // Divider never answers: watchdog exit after 64 WAIT cycles
    div_mute = 1'b1;
    bus.threshold = 16'd0;
    start_frame();
    for (int i = 0; i < 1024; i++) beat(1'b1, 1'b1);
    step();
    k = 0;
    while (!bus.result_valid && k < 200) begin
      step();
      k++;
    end
    check("wd_cycles", 32'(k), 32'd64);
    check("wd_err", 32'(bus.div_err), 32'd1);
    check("wd_score", 32'(bus.score), 32'd0);
    check("wd_match", 32'(bus.match), 32'd0);
    step();
    check("wd_err_hold", 32'(bus.div_err), 32'd1);
    start_frame();
    check("wd_err_clear", 32'(bus.div_err), 32'd0);
`else
    k = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vein_match_scorer.md
Name: vein_match_scorer

Overview:
- Sits directly upstream of the sequential 16-bit divider in the finger-vein matching path, and also consumes the divider's result.
- Streams one binarised template/probe pixel pair per accepted beat over a frame.
- Counts overlap pixels (both bits set) and union pixels (either bit set).
- Launches the divider with a scaled overlap/union ratio, captures the quotient as the match score, and compares it against a threshold to produce a match decision.

Parameters:
- FRAME_PIX, 1024: pixels per frame (1..65535).
- SCALE_SHIFT, 6: left shift applied to the overlap count before division.
- TIMEOUT, 64: watchdog limit in cycles, used only when MATCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse that begins a new frame
- pix_valid  in  1  pixel pair valid
- pix_ready  out  1  high in ACCUM only
- tmpl_bit  in  1  enrolled template pixel
- probe_bit  in  1  probe image pixel
- threshold  in  16  match threshold, sampled in DONE
- div_enable  out  1  single-cycle start pulse to the divider
- div_dividend  out  16  scaled overlap count
- div_divisor  out  16  union count
- div_quotient  in  16  divider quotient
- div_done  in  1  divider completion flag (level)
- score  out  16  last match score
- match  out  1  score >= threshold
- result_valid  out  1  single-cycle result strobe
- busy  out  1  high whenever state != IDLE
- div_err  out  1  watchdog error; exists only with MATCH_TIMEOUT_EN

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- Reset values: all outputs 0; pix_cnt, ovl_cnt and uni_cnt 0; state IDLE.
- States: IDLE, ACCUM, LAUNCH, WAIT, DONE.
- IDLE:
  - On frame_start, clear all counters and go to ACCUM.
  - pix_valid is ignored.
- ACCUM:
  - pix_ready = 1. A beat is accepted when pix_valid && pix_ready.
  - On each accepted beat: pix_cnt += 1; ovl_cnt += tmpl_bit & probe_bit; uni_cnt += tmpl_bit | probe_bit.
  - Counters are 16 bit and cannot overflow, since FRAME_PIX <= 65535.
  - frame_start in ACCUM clears the counters and stays in ACCUM. This takes priority over a beat in the same cycle; that beat is dropped.
  - On the beat that makes pix_cnt == FRAME_PIX:
    - If the final uni_cnt is 0, go to DONE with the zero-union flag set.
    - Otherwise go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - div_enable = 1.
  - div_dividend = min(ovl_cnt << SCALE_SHIFT, 16'hFFFF); computed at 32-bit width, then saturated.
  - div_divisor = uni_cnt.
  - Go to WAIT.
- WAIT:
  - div_enable = 0.
  - div_dividend and div_divisor are held stable until leaving WAIT.
  - div_done is sampled only in this state. On the first cycle it is high, register score <= div_quotient and go to DONE.
- DONE (exactly 1 cycle):
  - result_valid = 1.
  - match = (score >= threshold), unsigned.
  - Zero-union case: score = 0 and match = 0. The divider is never started (no div_enable pulse).
  - Next state is IDLE.
- frame_start in LAUNCH, WAIT or DONE is ignored.
- div_done outside WAIT is ignored.
- score and match hold until the next DONE.
- Latency: the last pixel is accepted at edge T.
  - Normal path: div_enable is high in cycle T+1; result_valid is high in the cycle after div_done is first seen in WAIT.
  - Zero-union path: result_valid is high in cycle T+1.
- Reset mid-operation: abort immediately, all outputs return to reset values, and the partial frame is discarded.

Optional Feature:
- Macro: MATCH_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in WAIT. If it reaches TIMEOUT without div_done, go to DONE with score = 0, match = 0, div_err = 1.
  - div_err holds until the next frame_start accepted in IDLE, or until reset.
  - The counter clears on every entry to WAIT.
- Undefined:
  - No watchdog and no div_err port; WAIT lasts indefinitely until div_done.

Test Plan:
- All 1024 pairs (1,1), threshold 32 -> div_dividend 65535 (saturated), div_divisor 1024; model quotient 63 -> score 63, match 1, result_valid for one cycle.
- 256 pairs (1,1), 256 pairs (1,0), 512 pairs (0,0), threshold 40 -> div_dividend 16384, div_divisor 512, score 32, match 0.
- All 1024 pairs (0,0) -> no div_enable pulse, result_valid in cycle T+1, score 0, match 0.
- Random pix_valid gaps, plus frame_start after 300 beats, then 1024 full beats -> counts reflect only the post-restart beats; a beat coincident with frame_start is dropped; frame_start during WAIT does not disturb the result.
- Reset asserted during WAIT, then a late div_done -> outputs 0, state IDLE, no result_valid; the next frame scores normally.
- MATCH_TIMEOUT_EN defined, TIMEOUT 64, div_done tied 0 -> result_valid after 64 WAIT cycles with div_err 1, score 0, match 0; div_err clears on the next frame_start.
